// File: rtl/myo_spi_fanout.sv
// SPI fan-out from the HPS master to up to 32 myocontrol boards.
// Routes MISO back from the selected board and monitors each frame.
module myo_spi_fanout #(
  parameter int NUM_SLAVES = 32,
  parameter int WORD_BITS  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_sclk,
  input  logic                  spi_mosi,
  input  logic [NUM_SLAVES-1:0] spi_ss_n,
  output logic                  spi_miso,
  output logic                  board_sclk,
  output logic                  board_mosi,
  output logic [NUM_SLAVES-1:0] board_ss_n,
  input  logic [NUM_SLAVES-1:0] board_miso,
  output logic                  frame_valid,
  output logic [4:0]            frame_slave,
  output logic [4:0]            frame_words,
  output logic [WORD_BITS-1:0]  frame_last_tx,
  output logic [WORD_BITS-1:0]  frame_last_rx,
  output logic                  err_multi_ss,
  output logic                  err_partial,
  input  logic                  err_clear
);

  localparam int BW = $clog2(WORD_BITS) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_BLOCK,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                  r_sclk;
  logic                  r_sclk_d;
  logic                  r_mosi;
  logic [NUM_SLAVES-1:0] r_ss_n;
  logic [NUM_SLAVES-1:0] r_miso_s1;
  logic [NUM_SLAVES-1:0] r_miso_s2;
  logic                  r_spi_miso;
  logic [4:0]            r_sel;
  logic                  r_sel_vld;
  logic [BW-1:0]         r_bit_cnt;
  logic [4:0]            r_word_cnt;
  logic [WORD_BITS-1:0]  r_tx_sr;
  logic [WORD_BITS-1:0]  r_rx_sr;
  logic [4:0]            r_frame_slave;
  logic [4:0]            r_frame_words;
  logic [WORD_BITS-1:0]  r_last_tx;
  logic [WORD_BITS-1:0]  r_last_rx;
  logic                  r_err_multi;
  logic                  r_err_partial;

  logic [NUM_SLAVES-1:0] w_low;
  logic                  w_none;
  logic                  w_multi;
  logic [4:0]            w_idx;
  logic [NUM_SLAVES-1:0] w_sel_mask;
  logic                  w_miso_sel;
  logic                  w_latch;
  logic                  w_done;
  logic                  w_set_multi;
  logic                  w_edge;
  logic                  w_word_end;
  logic [BW-1:0]         w_bit_nxt;
  logic [4:0]            w_word_nxt;
  logic [WORD_BITS-1:0]  w_tx_nxt;
  logic [WORD_BITS-1:0]  w_rx_nxt;
  logic                  w_set_partial;

  assign w_low   = ~r_ss_n;
  assign w_none  = (w_low == '0);
  assign w_multi = ((w_low & (w_low - NUM_SLAVES'(1))) != '0);

  always_comb begin
    w_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (w_low[i]) w_idx = 5'(i);
    end
  end

  always_comb begin
    w_sel_mask        = '1;
    w_sel_mask[r_sel] = 1'b0;
  end

  assign w_miso_sel = r_miso_s2[r_sel];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sclk    <= 1'b0;
      r_sclk_d  <= 1'b0;
      r_mosi    <= 1'b0;
      r_ss_n    <= '1;
      r_miso_s1 <= '0;
      r_miso_s2 <= '0;
    end else begin
      r_sclk    <= spi_sclk;
      r_sclk_d  <= r_sclk;
      r_mosi    <= spi_mosi;
      r_ss_n    <= spi_ss_n;
      r_miso_s1 <= board_miso;
      r_miso_s2 <= r_miso_s1;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_latch     = 1'b0;
    w_done      = 1'b0;
    w_set_multi = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_multi) begin
          w_set_multi = 1'b1;
          w_next      = S_BLOCK;
        end else if (!w_none) begin
          w_latch = 1'b1;
          w_next  = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (w_none) begin
          w_done = 1'b1;
          w_next = S_DONE;
        end else if (r_ss_n != w_sel_mask) begin
          w_set_multi = 1'b1;
          w_next      = S_BLOCK;
        end
      end
      S_BLOCK: begin
        if (w_none) w_next = S_IDLE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // A shift edge coinciding with SS release still lands in the frame.
  assign w_edge     = r_sclk & ~r_sclk_d & (r_state == S_ACTIVE);
  assign w_word_end = w_edge && (r_bit_cnt == BW'(WORD_BITS - 1));
  assign w_tx_nxt   = {r_tx_sr[WORD_BITS-2:0], r_mosi};
  assign w_rx_nxt   = {r_rx_sr[WORD_BITS-2:0], w_miso_sel};

  always_comb begin
    w_bit_nxt = r_bit_cnt;
    if (w_latch || w_word_end) w_bit_nxt = '0;
    else if (w_edge)           w_bit_nxt = r_bit_cnt + BW'(1);
  end

  always_comb begin
    w_word_nxt = r_word_cnt;
    if (w_latch) w_word_nxt = '0;
    else if (w_word_end && r_word_cnt != 5'd31)
      w_word_nxt = r_word_cnt + 5'd1;
  end

  assign w_set_partial = w_done && (w_bit_nxt != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel     <= '0;
      r_sel_vld <= 1'b0;
      r_bit_cnt <= '0;
      r_word_cnt <= '0;
      r_tx_sr   <= '0;
      r_rx_sr   <= '0;
    end else begin
      r_bit_cnt  <= w_bit_nxt;
      r_word_cnt <= w_word_nxt;
      if (w_latch) begin
        r_sel     <= w_idx;
        r_sel_vld <= 1'b1;
        r_tx_sr   <= '0;
        r_rx_sr   <= '0;
      end else begin
        if (w_next == S_IDLE || w_next == S_BLOCK)
          r_sel_vld <= 1'b0;
        if (w_edge) begin
          r_tx_sr <= w_tx_nxt;
          r_rx_sr <= w_rx_nxt;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_slave <= '0;
      r_frame_words <= '0;
      r_last_tx     <= '0;
      r_last_rx     <= '0;
      r_spi_miso    <= 1'b0;
    end else begin
      r_spi_miso <= r_sel_vld ? w_miso_sel : 1'b0;
      if (w_word_end) begin
        r_last_tx <= w_tx_nxt;
        r_last_rx <= w_rx_nxt;
      end
      if (w_done) begin
        r_frame_slave <= r_sel;
        r_frame_words <= w_word_nxt;
      end
    end
  end

  // Setting a flag wins over a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_multi   <= 1'b0;
      r_err_partial <= 1'b0;
    end else begin
      if (w_set_multi)    r_err_multi <= 1'b1;
      else if (err_clear) r_err_multi <= 1'b0;
      if (w_set_partial)  r_err_partial <= 1'b1;
      else if (err_clear) r_err_partial <= 1'b0;
    end
  end

  // Illegal multi-select patterns never reach the boards.
  always_comb begin
    board_ss_n = '1;
    if ((r_state == S_IDLE || r_state == S_ACTIVE) && !w_multi)
      board_ss_n = r_ss_n;
  end

  assign board_sclk    = r_sclk;
  assign board_mosi    = r_mosi;
  assign spi_miso      = r_spi_miso;
  assign frame_valid   = (r_state == S_DONE);
  assign frame_slave   = r_frame_slave;
  assign frame_words   = r_frame_words;
  assign frame_last_tx = r_last_tx;
  assign frame_last_rx = r_last_rx;
  assign err_multi_ss  = r_err_multi;
  assign err_partial   = r_err_partial;

endmodule
